// File: rtl/sr_shift_seq_pkg.sv
// Shared encodings for the shift-register sequencer: FSM states and shift direction.
package sr_pkg;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_SHIFT   = 1'b1;

    localparam logic       DIR_RIGHT = 1'b0;
    localparam logic       DIR_LEFT  = 1'b1;

endpackage

// File: rtl/sr_shift_seq_if.sv
// Control/data bundle of the serial shift engine; master drives controls, slave is the engine.
interface sr_shift_seq_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             CE;
    logic             L;
    logic [WIDTH-1:0] D;
    logic             SH;
    logic             DIR;
    logic             SRI;
    logic             START;
    logic [CW-1:0]    LEN;
    logic [WIDTH-1:0] Q;
    logic             SO;
    logic             BUSY;
    logic             DONE;

    modport master (
        output CE, L, D, SH, DIR, SRI, START, LEN,
        input  Q, SO, BUSY, DONE
    );

    modport slave (
        input  CE, L, D, SH, DIR, SRI, START, LEN,
        output Q, SO, BUSY, DONE
    );

endinterface

// File: rtl/sr_shift_seq_core.sv
// Datapath register: parallel load, one-bit shift in either direction, serial-out mux.
module sr_shift_core
    import sr_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift,
    input  logic             dir,
    input  logic             sri,
    output logic [WIDTH-1:0] q,
    output logic             so
);

    always_ff @(posedge C) begin
        if (!CLR_N)
            q <= RST_VAL;
        else if (load)
            q <= d;
        else if (shift)
            q <= (dir == DIR_LEFT) ? {q[WIDTH-2:0], sri} : {sri, q[WIDTH-1:1]};
    end

    // The bit that leaves the register on the next shift in the active direction.
    assign so = (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/sr_shift_seq.sv
// Parametrised shift register with manual shift mode and an autonomous LEN-bit burst sequencer.
module sr_shift_seq
    import sr_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic C,
    input  logic CLR_N,
    sr_shift_seq_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic             dir_r;
    logic             done;

    logic             idle;
    logic             load;
    logic             start_ok;
    logic             man_shift;
    logic             burst_shift;
    logic             act_dir;
    logic [WIDTH-1:0] q;
    logic             so;

    assign idle        = (state == S_IDLE);
    assign load        = idle && bus.L;
    assign start_ok    = idle && !bus.L && bus.START;
    assign man_shift   = idle && !bus.L && !bus.START && bus.SH && bus.CE;
    assign burst_shift = (state == S_SHIFT) && bus.CE;
    // A running burst keeps the direction captured at START.
    assign act_dir     = idle ? bus.DIR : dir_r;

    always_ff @(posedge C) begin
        if (!CLR_N) begin
            state <= S_IDLE;
            cnt   <= '0;
            dir_r <= DIR_RIGHT;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        dir_r <= bus.DIR;
                        cnt   <= (bus.LEN == '0) ? CW'(WIDTH) : bus.LEN;
                        state <= S_SHIFT;
                    end
                end
                default: begin
                    if (bus.CE) begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    sr_shift_core #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_core (
        .C     (C),
        .CLR_N (CLR_N),
        .load  (load),
        .d     (bus.D),
        .shift (man_shift || burst_shift),
        .dir   (act_dir),
        .sri   (bus.SRI),
        .q     (q),
        .so    (so)
    );

    assign bus.Q    = q;
    assign bus.SO   = so;
    assign bus.BUSY = (state == S_SHIFT);
    assign bus.DONE = done;

endmodule

// File: tb/tb_sr_shift_seq.sv
// Bench for sr_shift_seq: per-scenario tasks, expected serial-out bits queued at START.
module tb_sr_shift_seq;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic C = 1'b0;
    logic CLR_N;
    always #5 C = ~C;

    sr_shift_seq_if #(.WIDTH(W)) bus();

    sr_shift_seq #(.WIDTH(W)) dut (
        .C     (C),
        .CLR_N (CLR_N),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    logic exp_so[$];

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic idle_inputs();
        bus.CE = 1'b0; bus.L = 1'b0; bus.D = '0; bus.SH = 1'b0;
        bus.DIR = 1'b0; bus.SRI = 1'b0; bus.START = 1'b0; bus.LEN = '0;
    endtask

    task automatic load_reg(input logic [W-1:0] v);
        bus.L = 1'b1; bus.D = v;
        tick();
        bus.L = 1'b0;
    endtask

    // Reference model of a burst with constant SRI: queues the SO stream.
    task automatic expect_burst(input logic [W-1:0] v, input int len, input logic dir,
                                input logic sri, output logic [W-1:0] fin);
        logic [W-1:0] m;
        m = v;
        for (int i = 0; i < len; i++) begin
            exp_so.push_back(dir ? m[W-1] : m[0]);
            m = dir ? {m[W-2:0], sri} : {sri, m[W-1:1]};
        end
        fin = m;
    endtask

    task automatic test_reset();
        bus.CE = 1'($urandom); bus.L = 1'($urandom); bus.D = W'($urandom);
        bus.SH = 1'($urandom); bus.SRI = 1'($urandom); bus.START = 1'b1;
        bus.LEN = CW'($urandom); bus.DIR = 1'b1;
        CLR_N = 1'b0;
        tick(); tick();
        checks++; if (bus.Q !== 16'h0000) begin errors++; $display("FAIL reset_q got=%h want=0000", bus.Q); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.DONE); end
        checks++; if (bus.SO !== 1'b0) begin errors++; $display("FAIL reset_so got=%b want=0", bus.SO); end
        CLR_N = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_load_manual();
        load_reg(16'hA5C3);
        checks++; if (bus.Q !== 16'hA5C3) begin errors++; $display("FAIL load_ce0 got=%h want=a5c3", bus.Q); end
        bus.SH = 1'b1; bus.CE = 1'b1; bus.DIR = 1'b0; bus.SRI = 1'b1;
        tick();
        checks++; if (bus.Q !== 16'hD2E1) begin errors++; $display("FAIL manual_right got=%h want=d2e1", bus.Q); end
        bus.DIR = 1'b1; bus.SRI = 1'b0;
        tick();
        checks++; if (bus.Q !== 16'hA5C2) begin errors++; $display("FAIL manual_left got=%h want=a5c2", bus.Q); end
        bus.CE = 1'b0;
        tick();
        checks++; if (bus.Q !== 16'hA5C2) begin errors++; $display("FAIL manual_ce0_hold got=%h want=a5c2", bus.Q); end
        idle_inputs();
        bus.L = 1'b1; bus.D = 16'h1111; bus.START = 1'b1; bus.LEN = 5'd4; bus.CE = 1'b1;
        tick();
        idle_inputs();
        checks++; if (bus.Q !== 16'h1111) begin errors++; $display("FAIL load_start_q got=%h want=1111", bus.Q); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL load_start_busy got=%b want=0", bus.BUSY); end
    endtask

    task automatic test_burst_full();
        int busy_n = 0, done_k = -1;
        logic want;
        load_reg(16'h8001);
        exp_so.push_back(1'b1);
        for (int i = 0; i < 14; i++) exp_so.push_back(1'b0);
        exp_so.push_back(1'b1);
        bus.START = 1'b1; bus.LEN = 5'd0; bus.DIR = 1'b0; bus.SRI = 1'b0; bus.CE = 1'b1;
        tick();
        bus.START = 1'b0;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (bus.DONE) begin done_k = k; break; end
            if (!bus.BUSY) break;
            busy_n++;
            want = (exp_so.size() > 0) ? exp_so.pop_front() : 1'bx;
            checks++; if (bus.SO !== want) begin errors++; $display("FAIL full_so bit=%0d got=%b want=%b", k, bus.SO, want); end
            tick();
        end
        checks++; if (done_k != 16) begin errors++; $display("FAIL full_done_cycle got=%0d want=16", done_k); end
        checks++; if (busy_n != 16) begin errors++; $display("FAIL full_busy_cycles got=%0d want=16", busy_n); end
        checks++; if (bus.Q !== 16'h0000) begin errors++; $display("FAIL full_q got=%h want=0000", bus.Q); end
        tick();
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL full_done_width got=%b want=0", bus.DONE); end
        checks++; if (exp_so.size() != 0) begin errors++; $display("FAIL full_sb_left got=%0d want=0", exp_so.size()); end
        exp_so.delete();
        idle_inputs();
    endtask

    task automatic test_stall();
        int done_k = -1;
        logic want;
        load_reg(16'hF000);
        for (int i = 0; i < 4; i++) exp_so.push_back(1'b1);
        bus.START = 1'b1; bus.LEN = 5'd4; bus.DIR = 1'b1; bus.SRI = 1'b1; bus.CE = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.CE = (k == 1) ? 1'b0 : 1'b1;
            #1;
            if (bus.DONE) begin done_k = k; break; end
            if (!bus.BUSY) break;
            if (k == 1 || k == 2) begin
                checks++; if (bus.Q !== 16'hE001) begin errors++; $display("FAIL stall_hold k=%0d got=%h want=e001", k, bus.Q); end
            end
            if (bus.CE) begin
                want = (exp_so.size() > 0) ? exp_so.pop_front() : 1'bx;
                checks++; if (bus.SO !== want) begin errors++; $display("FAIL stall_so k=%0d got=%b want=%b", k, bus.SO, want); end
            end
            tick();
        end
        checks++; if (done_k != 5) begin errors++; $display("FAIL stall_done_cycle got=%0d want=5", done_k); end
        checks++; if (bus.Q !== 16'h000F) begin errors++; $display("FAIL stall_q got=%h want=000f", bus.Q); end
        checks++; if (exp_so.size() != 0) begin errors++; $display("FAIL stall_sb_left got=%0d want=0", exp_so.size()); end
        exp_so.delete();
        idle_inputs();
        tick();
    endtask

    task automatic test_ignored_inputs();
        int done_k = -1;
        logic want;
        logic [W-1:0] fin;
        load_reg(16'h3C5A);
        expect_burst(16'h3C5A, 8, 1'b0, 1'b0, fin);
        bus.START = 1'b1; bus.LEN = 5'd8; bus.DIR = 1'b0; bus.SRI = 1'b0; bus.CE = 1'b1;
        tick();
        for (int k = 0; k < 30; k++) begin
            if (bus.DONE) begin done_k = k; idle_inputs(); break; end
            if (!bus.BUSY) break;
            bus.L = 1'b1; bus.D = 16'hFFFF; bus.START = 1'b1; bus.SH = 1'b1;
            bus.LEN = 5'd3; bus.DIR = k[0];
            #1;
            want = (exp_so.size() > 0) ? exp_so.pop_front() : 1'bx;
            checks++; if (bus.SO !== want) begin errors++; $display("FAIL ignore_so k=%0d got=%b want=%b", k, bus.SO, want); end
            tick();
        end
        checks++; if (done_k != 8) begin errors++; $display("FAIL ignore_done_cycle got=%0d want=8", done_k); end
        checks++; if (bus.Q !== 16'h003C) begin errors++; $display("FAIL ignore_q got=%h want=003c", bus.Q); end
        tick();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got=%b want=0", bus.BUSY); end
        checks++; if (bus.Q !== fin) begin errors++; $display("FAIL ignore_q_hold got=%h want=%h", bus.Q, fin); end
        exp_so.delete();
    endtask

    task automatic test_daisy_chain();
        int done_k = -1;
        logic want;
        logic [W-1:0] fin;
        load_reg(16'hF00F);
        expect_burst(16'hF00F, 20, 1'b0, 1'b1, fin);
        bus.START = 1'b1; bus.LEN = 5'd20; bus.DIR = 1'b0; bus.SRI = 1'b1; bus.CE = 1'b1;
        tick();
        bus.START = 1'b0;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (bus.DONE) begin done_k = k; break; end
            if (!bus.BUSY) break;
            want = (exp_so.size() > 0) ? exp_so.pop_front() : 1'bx;
            checks++; if (bus.SO !== want) begin errors++; $display("FAIL daisy_so k=%0d got=%b want=%b", k, bus.SO, want); end
            tick();
        end
        checks++; if (done_k != 20) begin errors++; $display("FAIL daisy_done_cycle got=%0d want=20", done_k); end
        checks++; if (bus.Q !== 16'hFFFF) begin errors++; $display("FAIL daisy_q got=%h want=ffff", bus.Q); end
        exp_so.delete();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        load_reg(16'hAAAA);
        bus.START = 1'b1; bus.LEN = 5'd8; bus.DIR = 1'b0; bus.SRI = 1'b0; bus.CE = 1'b1;
        tick();
        bus.START = 1'b0;
        tick(); tick();
        checks++; if (bus.Q !== 16'h2AAA) begin errors++; $display("FAIL midrst_pre_q got=%h want=2aaa", bus.Q); end
        CLR_N = 1'b0;
        tick();
        checks++; if (bus.Q !== 16'h0000) begin errors++; $display("FAIL midrst_q got=%h want=0000", bus.Q); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", bus.BUSY); end
        CLR_N = 1'b1;
        tick();
        checks++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++; $display("FAIL midrst_after got=%b%b want=00", bus.DONE, bus.BUSY);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int done_k = -1;
        logic want;
        load_reg(16'h0001);
        exp_so.push_back(1'b1); exp_so.push_back(1'b0);
        bus.START = 1'b1; bus.LEN = 5'd2; bus.DIR = 1'b0; bus.SRI = 1'b0; bus.CE = 1'b1;
        tick();
        bus.START = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (bus.DONE) begin done_k = k; break; end
            if (!bus.BUSY) break;
            want = (exp_so.size() > 0) ? exp_so.pop_front() : 1'bx;
            checks++; if (bus.SO !== want) begin errors++; $display("FAIL b2b_so k=%0d got=%b want=%b", k, bus.SO, want); end
            tick();
        end
        checks++; if (done_k != 2) begin errors++; $display("FAIL b2b_done_cycle got=%0d want=2", done_k); end
        checks++; if (bus.Q !== 16'h0000) begin errors++; $display("FAIL b2b_q1 got=%h want=0000", bus.Q); end
        // START in the DONE cycle: one-bit left burst shifting in a 1
        bus.START = 1'b1; bus.LEN = 5'd1; bus.DIR = 1'b1; bus.SRI = 1'b1;
        exp_so.push_back(1'b0);
        tick();
        bus.START = 1'b0; bus.DIR = 1'b0;
        #1;
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b want=1", bus.BUSY); end
        want = (exp_so.size() > 0) ? exp_so.pop_front() : 1'bx;
        checks++; if (bus.SO !== want) begin errors++; $display("FAIL b2b_so2 got=%b want=%b", bus.SO, want); end
        tick();
        checks++; if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++; $display("FAIL b2b_done2 got=%b%b want=10", bus.DONE, bus.BUSY);
        end
        checks++; if (bus.Q !== 16'h0001) begin errors++; $display("FAIL b2b_q2 got=%h want=0001", bus.Q); end
        tick();
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL b2b_done2_width got=%b want=0", bus.DONE); end
        exp_so.delete();
        idle_inputs();
    endtask

    initial begin
        CLR_N = 1'b1;
        idle_inputs();
        test_reset();
        test_load_manual();
        test_burst_full();
        test_stall();
        test_ignored_inputs();
        test_daisy_chain();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
